// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART TX path (frame_gen, uart_piso).
//   - state encoding for the PISO sequencer
//   - parity_type codes
//   - default frame width
//   - frame_len(): active frame length derived from the line configuration
// -----------------------------------------------------------------------------
package uart_pkg;

  // Maximum frame length: start + 8 data + parity + 2 stop.
  localparam int FRAME_W_DEF = 12;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE_C  = 2'd0;
  localparam logic [1:0] ST_WAIT_C  = 2'd1;
  localparam logic [1:0] ST_TX_C    = 2'd2;
  localparam logic [1:0] ST_GUARD_C = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_WAIT  = ST_WAIT_C,
    ST_TX    = ST_TX_C,
    ST_GUARD = ST_GUARD_C
  } piso_state_e;

  // parity_type codes; anything other than PAR_NONE adds one parity bit.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_EXT  = 2'b11;

  // Number of bits on the line for one frame (9..12).
  function automatic logic [3:0] frame_len(input logic [1:0] parity_type,
                                           input logic       stop_bits,
                                           input logic       data_length);
    logic [3:0] len;
    len = 4'd1;
    len = len + (data_length ? 4'd8 : 4'd7);
    len = len + ((parity_type != PAR_NONE) ? 4'd1 : 4'd0);
    len = len + (stop_bits ? 4'd2 : 4'd1);
    return len;
  endfunction

endpackage

// File: rtl/uart_piso_if.sv
// -----------------------------------------------------------------------------
// uart_piso_if
// Handshake/config bundle between the TX controller side and uart_piso.
//   baud_tick    bit-period strobe (one clk wide)
//   send         load request for frame_in
//   frame_in     frame from frame_gen, bit0 = start bit, unused MSBs = 1
//   parity_type  00 none, otherwise a parity bit is present
//   stop_bits    0 = one stop bit, 1 = two
//   data_length  0 = 7 data bits, 1 = 8
//   data_tx      serial line (idle high)
//   active_flag  frame in progress
//   done_flag    one-clk end-of-frame pulse
// Modports: master = controller/testbench side, slave = uart_piso.
// -----------------------------------------------------------------------------
interface uart_piso_if
  import uart_pkg::*;
();

  logic                   baud_tick;
  logic                   send;
  logic [FRAME_W_DEF-1:0] frame_in;
  logic [1:0]             parity_type;
  logic                   stop_bits;
  logic                   data_length;
  logic                   data_tx;
  logic                   active_flag;
  logic                   done_flag;

  modport master (
    output baud_tick, send, frame_in, parity_type, stop_bits, data_length,
    input  data_tx, active_flag, done_flag
  );

  modport slave (
    input  baud_tick, send, frame_in, parity_type, stop_bits, data_length,
    output data_tx, active_flag, done_flag
  );

endinterface

// File: rtl/uart_piso.sv
// -----------------------------------------------------------------------------
// uart_piso
// Parallel-in/serial-out stage of the UART TX path. On send (while idle) it
// captures the frame and its length; the start bit is launched on the next
// baud_tick so it lasts a full bit period, then one bit per tick, LSB first.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   bus    uart_piso_if.slave (baud_tick, send, frame_in, config in;
//          data_tx, active_flag, done_flag out - all outputs registered)
//
// Optional feature macro: UART_PISO_IDLE_GUARD_EN
//   When defined, one extra high bit period (GUARD) follows the last stop
//   bit with active_flag still high; done_flag pulses at the end of GUARD.
// -----------------------------------------------------------------------------
module uart_piso
  import uart_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  uart_piso_if.slave  bus
);

  piso_state_e        state_q;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   last_idx_q;
  logic               data_tx_q;
  logic               active_q;
  logic               done_q;
  logic [CNT_W-1:0]   last_idx_d;

  // Index of the final bit for the configuration presented at load time.
  always_comb begin
    last_idx_d = CNT_W'(frame_len(bus.parity_type, bus.stop_bits, bus.data_length))
                 - CNT_W'(1);
  end

  // Sequencer: load, start-bit alignment, bit shifting and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      last_idx_q <= '0;
      data_tx_q  <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // done_flag is a single-cycle pulse unless set below.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          data_tx_q <= 1'b1;
          // A coincident baud_tick is deliberately ignored here so the
          // start bit always begins on a tick edge.
          if (bus.send) begin
            shift_q    <= bus.frame_in;
            last_idx_q <= last_idx_d;
            active_q   <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.baud_tick) begin
            data_tx_q <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= ST_TX;
          end
        end
        ST_TX: begin
          if (bus.baud_tick) begin
            if (bit_cnt_q == last_idx_q) begin
              data_tx_q <= 1'b1;
              shift_q   <= '1;
`ifdef UART_PISO_IDLE_GUARD_EN
              state_q   <= ST_GUARD;
`else
              active_q  <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
`endif
            end else begin
              // Shift toward bit0 with 1-fill so stale bits read as idle.
              shift_q   <= {1'b1, shift_q[FRAME_W-1:1]};
              data_tx_q <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef UART_PISO_IDLE_GUARD_EN
        ST_GUARD: begin
          data_tx_q <= 1'b1;
          if (bus.baud_tick) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q   <= ST_IDLE;
          shift_q   <= '1;
          data_tx_q <= 1'b1;
          active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_tx     = data_tx_q;
  assign bus.active_flag = active_q;
  assign bus.done_flag   = done_q;

endmodule
